adc_frame_buffer: RTL and testbench

ADC_FRAME_BUFFER -- requirements
Module: adc_frame_buffer

---
 rtl/adc_frame_buffer.sv | 179 +++++++++++++++++
 tb/tb_adc_frame_buffer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_buffer.sv
// adc_frame_buffer
//   Captures one frame of FRAME_LEN ADC samples into an on-chip buffer, then
//   holds it for a downstream smoothing filter. The filter reads samples at
//   random with one cycle of latency and hands the frame back when finished.
//
//   Flow: IDLE --arm--> CAPTURE --FRAME_LEN samples--> READY --release--> IDLE
//         (arm together with release in READY goes straight back to CAPTURE;
//          arm during CAPTURE restarts the frame at index 0)
//
// Ports
//   clk            single clock, all state changes on its rising edge
//   rst            asynchronous active-high reset
//   arm            request to begin capturing a new frame
//   adc_valid      qualifies adc_data for one cycle
//   adc_data       unsigned ADC sample, DATA_WIDTH bits
//   rd_en          read request from the filter (honoured only in READY)
//   rd_addr        sample index to read
//   frame_release  filter has finished with the frame ("release" is a
//                  reserved word in SystemVerilog, hence the longer name)
//   rd_data        read sample, valid when rd_valid is high
//   rd_valid       rd_data is valid this cycle
//   start          one-cycle pulse in the first READY cycle
//   frame_ready    high while a complete frame is held (READY)
//   busy           high while capturing (CAPTURE)
//   sample_count   samples stored in the current frame
//   overrun        sticky: a sample arrived while a frame was held
module adc_frame_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 1000,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  adc_valid,
  input  logic [DATA_WIDTH-1:0] adc_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  frame_release,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  start,
  output logic                  frame_ready,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] sample_count,
  output logic                  overrun
);

  // Index of the final sample of a frame and the full-frame count.
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(FRAME_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] FULL_CNT = ADDR_WIDTH'(FRAME_LEN);
  // Range limit kept one bit wider so rd_addr compares correctly even when
  // FRAME_LEN fills the whole address space.
  localparam logic [ADDR_WIDTH:0]   RD_LIMIT = (ADDR_WIDTH + 1)'(FRAME_LEN);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_READY   = 2'd2
  } state_t;

  state_t state_reg;

  // Sample storage; contents are never cleared, reset only abandons a frame.
  logic [DATA_WIDTH-1:0] mem [0:FRAME_LEN-1];

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  rd_accept;
  logic                  rd_in_range;

  always_comb begin
    wr_en       = 1'b0;
    wr_addr     = sample_count;
    rd_accept   = 1'b0;
    rd_in_range = 1'b0;
    if (state_reg == ST_CAPTURE) begin
      wr_en = adc_valid;
      // A restart (arm) during capture places a coincident sample at index 0.
      if (arm) begin
        wr_addr = '0;
      end
    end
    rd_accept   = (state_reg == ST_READY) && rd_en;
    rd_in_range = ({1'b0, rd_addr} < RD_LIMIT);
  end

  // Buffer write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= adc_data;
    end
  end

  // Registered read port. rd_data keeps its last value when no read is
  // accepted; out-of-frame addresses return zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_accept;
      if (rd_accept) begin
        if (rd_in_range) begin
          rd_data <= mem[rd_addr];
        end else begin
          rd_data <= '0;
        end
      end
    end
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      start        <= 1'b0;
      frame_ready  <= 1'b0;
      busy         <= 1'b0;
      sample_count <= '0;
      overrun      <= 1'b0;
    end else begin
      start <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (arm) begin
            state_reg    <= ST_CAPTURE;
            busy         <= 1'b1;
            frame_ready  <= 1'b0;
            sample_count <= '0;
            overrun      <= 1'b0;
          end
        end

        ST_CAPTURE: begin
          if (wr_en) begin
            if (wr_addr == LAST_IDX) begin
              // This write completes the frame.
              state_reg    <= ST_READY;
              busy         <= 1'b0;
              frame_ready  <= 1'b1;
              start        <= 1'b1;
              sample_count <= FULL_CNT;
            end else begin
              sample_count <= wr_addr + 1'b1;
            end
          end else if (arm) begin
            sample_count <= '0;
          end
        end

        ST_READY: begin
          if (adc_valid) begin
            overrun <= 1'b1;
          end
          if (frame_release) begin
            frame_ready <= 1'b0;
            if (arm) begin
              // Accepted arm wins over a coincident overrun sample.
              state_reg    <= ST_CAPTURE;
              busy         <= 1'b1;
              sample_count <= '0;
              overrun      <= 1'b0;
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end

        default: begin
          state_reg   <= ST_IDLE;
          busy        <= 1'b0;
          frame_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_buffer.sv
// Testbench for adc_frame_buffer (default parameters). Inputs are driven 1 ns
// after each rising edge and outputs are sampled at the same point, so every
// observation reflects the edge just taken. Expected read data is pushed to a
// scoreboard queue when a read is issued and popped when rd_valid appears.
module tb_adc_frame_buffer;

  localparam int DW = 8;
  localparam int FL = 1000;
  localparam int AW = 10;

  logic          clk;
  logic          rst;
  logic          arm;
  logic          adc_valid;
  logic [DW-1:0] adc_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          frame_release;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          start;
  logic          frame_ready;
  logic          busy;
  logic [AW-1:0] sample_count;
  logic          overrun;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] model_mem [0:1023];
  logic [DW-1:0] exp_q [$];
  int            addr_q [$];

  adc_frame_buffer #(
    .DATA_WIDTH(DW),
    .FRAME_LEN (FL),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .adc_valid    (adc_valid),
    .adc_data     (adc_data),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .frame_release(frame_release),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .start        (start),
    .frame_ready  (frame_ready),
    .busy         (busy),
    .sample_count (sample_count),
    .overrun      (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] model_val(input int a);
    if (a >= FL) return '0;
    return model_mem[a];
  endfunction

  // Feed n consecutive samples starting at index idx, value (i*mul+add)%256.
  task automatic feed_samples(input int idx, input int n, input int mul, input int add);
    for (int k = 0; k < n; k++) begin
      adc_valid = 1'b1;
      adc_data  = DW'(((idx + k) * mul + add) % 256);
      model_mem[idx + k] = adc_data;
      step();
    end
    adc_valid = 1'b0;
  endtask

  // Issue the reads in addr_q back to back, one per cycle.
  task automatic do_reads();
    logic [DW-1:0] exp_v;
    for (int i = 0; i < addr_q.size(); i++) begin
      rd_en   = 1'b1;
      rd_addr = AW'(addr_q[i]);
      exp_q.push_back(model_val(addr_q[i]));
      step();
      tests_run++;
      if (rd_valid !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL read_valid addr=%0d got=%b exp=1", addr_q[i], rd_valid);
      end
      exp_v = exp_q.pop_front();
      tests_run++;
      if (rd_data !== exp_v) begin
        tests_failed++;
        $display("[TB] FAIL read_data addr=%0d got=%0d exp=%0d", addr_q[i], rd_data, exp_v);
      end
      $display("[TB] read addr=%0d data=%0d valid=%b", addr_q[i], rd_data, rd_valid);
    end
    rd_en = 1'b0;
    addr_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    tests_run++;
    if ({busy, frame_ready, start, rd_valid, overrun} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags got=%b exp=00000", {busy, frame_ready, start, rd_valid, overrun});
    end
    tests_run++;
    if (sample_count !== '0 || rd_data !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_values count=%0d data=%0d exp=0/0", sample_count, rd_data);
    end
    step();
    rst = 1'b0;
    step();
    // IDLE ignores samples.
    adc_valid = 1'b1;
    adc_data  = 8'h33;
    step();
    adc_valid = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || sample_count !== '0) begin
      tests_failed++;
      $display("[TB] FAIL idle_ignore busy=%b count=%0d exp=0/0", busy, sample_count);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_capture_frame();
    arm = 1'b1;
    step();
    arm = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || frame_ready !== 1'b0 || sample_count !== '0) begin
      tests_failed++;
      $display("[TB] FAIL arm_capture busy=%b ready=%b count=%0d exp=1/0/0", busy, frame_ready, sample_count);
    end
    feed_samples(0, FL - 1, 1, 0);
    tests_run++;
    if (start !== 1'b0 || sample_count !== AW'(FL - 1) || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pre_last start=%b count=%0d busy=%b exp=0/999/1", start, sample_count, busy);
    end
    feed_samples(FL - 1, 1, 1, 0);
    tests_run++;
    if (start !== 1'b1 || frame_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL frame_done start=%b ready=%b busy=%b exp=1/1/0", start, frame_ready, busy);
    end
    tests_run++;
    if (sample_count !== AW'(FL)) begin
      tests_failed++;
      $display("[TB] FAIL full_count got=%0d exp=%0d", sample_count, FL);
    end
    step();
    tests_run++;
    if (start !== 1'b0 || frame_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL start_pulse start=%b ready=%b exp=0/1", start, frame_ready);
    end
    $display("[TB] test_capture_frame done");
  endtask

  task automatic test_back_to_back();
    addr_q.push_back(0);
    addr_q.push_back(1);
    addr_q.push_back(999);
    addr_q.push_back(1000);
    do_reads();
    step();
    tests_run++;
    if (rd_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL read_idle_valid got=%b exp=0", rd_valid);
    end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_overrun();
    adc_valid = 1'b1;
    adc_data  = 8'hEE;
    step();
    adc_valid = 1'b0;
    tests_run++;
    if (overrun !== 1'b1 || sample_count !== AW'(FL) || frame_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL overrun_set ovr=%b count=%0d ready=%b exp=1/1000/1", overrun, sample_count, frame_ready);
    end
    // arm without release is ignored; overrun stays sticky
    arm = 1'b1;
    step();
    arm = 1'b0;
    step();
    tests_run++;
    if (frame_ready !== 1'b1 || busy !== 1'b0 || overrun !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL arm_no_release ready=%b busy=%b ovr=%b exp=1/0/1", frame_ready, busy, overrun);
    end
    addr_q.push_back(5);
    do_reads();
    $display("[TB] test_overrun done");
  endtask

  task automatic test_arm_release();
    arm = 1'b1;
    frame_release = 1'b1;
    step();
    arm = 1'b0;
    frame_release = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || frame_ready !== 1'b0 || sample_count !== '0) begin
      tests_failed++;
      $display("[TB] FAIL arm_release busy=%b ready=%b count=%0d exp=1/0/0", busy, frame_ready, sample_count);
    end
    tests_run++;
    if (overrun !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL overrun_clear got=%b exp=0", overrun);
    end
    $display("[TB] test_arm_release done");
  endtask

  task automatic test_restart();
    feed_samples(0, 500, 3, 7);
    tests_run++;
    if (sample_count !== AW'(500)) begin
      tests_failed++;
      $display("[TB] FAIL count_500 got=%0d exp=500", sample_count);
    end
    // release during capture is ignored
    frame_release = 1'b1;
    step();
    frame_release = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || sample_count !== AW'(500)) begin
      tests_failed++;
      $display("[TB] FAIL release_in_capture busy=%b count=%0d exp=1/500", busy, sample_count);
    end
    arm       = 1'b1;
    adc_valid = 1'b1;
    adc_data  = 8'hAA;
    model_mem[0] = 8'hAA;
    step();
    arm       = 1'b0;
    adc_valid = 1'b0;
    tests_run++;
    if (sample_count !== AW'(1) || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL restart_count count=%0d busy=%b exp=1/1", sample_count, busy);
    end
    feed_samples(1, FL - 1, 5, 1);
    tests_run++;
    if (start !== 1'b1 || sample_count !== AW'(FL)) begin
      tests_failed++;
      $display("[TB] FAIL restart_done start=%b count=%0d exp=1/1000", start, sample_count);
    end
    addr_q.push_back(1);
    addr_q.push_back(500);
    addr_q.push_back(0);
    do_reads();
    $display("[TB] test_restart done");
  endtask

  task automatic test_release_with_read();
    logic [DW-1:0] held;
    rd_en   = 1'b1;
    rd_addr = AW'(2);
    frame_release = 1'b1;
    exp_q.push_back(model_val(2));
    step();
    rd_en = 1'b0;
    frame_release = 1'b0;
    held = exp_q.pop_front();
    tests_run++;
    if (rd_valid !== 1'b1 || rd_data !== held) begin
      tests_failed++;
      $display("[TB] FAIL read_on_release valid=%b data=%0d exp=1/%0d", rd_valid, rd_data, held);
    end
    tests_run++;
    if (frame_ready !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL release_idle ready=%b busy=%b exp=0/0", frame_ready, busy);
    end
    // read in IDLE ignored, data held; a sample in IDLE raises nothing
    rd_en     = 1'b1;
    rd_addr   = AW'(3);
    adc_valid = 1'b1;
    adc_data  = 8'h55;
    step();
    rd_en     = 1'b0;
    adc_valid = 1'b0;
    tests_run++;
    if (rd_valid !== 1'b0 || rd_data !== held) begin
      tests_failed++;
      $display("[TB] FAIL read_in_idle valid=%b data=%0d exp=0/%0d", rd_valid, rd_data, held);
    end
    tests_run++;
    if (overrun !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL sample_in_idle ovr=%b busy=%b exp=0/0", overrun, busy);
    end
    $display("[TB] test_release_with_read done");
  endtask

  task automatic test_async_reset();
    arm = 1'b1;
    step();
    arm = 1'b0;
    feed_samples(0, 300, 1, 0);
    tests_run++;
    if (sample_count !== AW'(300) || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL count_300 count=%0d busy=%b exp=300/1", sample_count, busy);
    end
    #3;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, frame_ready, start, rd_valid, overrun} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_flags got=%b exp=00000", {busy, frame_ready, start, rd_valid, overrun});
    end
    tests_run++;
    if (sample_count !== '0 || rd_data !== '0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset_values count=%0d data=%0d exp=0/0", sample_count, rd_data);
    end
    #2;
    rst = 1'b0;
    step();
    rd_en   = 1'b1;
    rd_addr = AW'(0);
    step();
    rd_en = 1'b0;
    tests_run++;
    if (rd_valid !== 1'b0 || busy !== 1'b0 || frame_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_read valid=%b busy=%b ready=%b exp=0/0/0", rd_valid, busy, frame_ready);
    end
    $display("[TB] test_async_reset done");
  endtask

  initial begin
    arm           = 1'b0;
    adc_valid     = 1'b0;
    adc_data      = '0;
    rd_en         = 1'b0;
    rd_addr       = '0;
    frame_release = 1'b0;
    rst           = 1'b0;
    for (int i = 0; i < 1024; i++) model_mem[i] = '0;

    test_reset();
    test_capture_frame();
    test_back_to_back();
    test_overrun();
    test_arm_release();
    test_restart();
    test_release_with_read();
    test_async_reset();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
